// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with step/redirect/trap and a circular return-address stack
// Ports: clk, rst_n (async active-low); en advances state; half selects 2-byte step when C_EXT=1;
// load/call/ret/trap with target/trap_vector choose the next pc; ras_flush empties the stack.
// Outputs: pc (registered), pc_plus_len (pc + step), ras_top, ras_count, ras_lost (sticky overflow).
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4,
  parameter bit C_EXT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       half,
  input  logic                       load,
  input  logic [WIDTH-1:0]           target,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       trap,
  input  logic [WIDTH-1:0]           trap_vector,
  input  logic                       ras_flush,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_plus_len,
  output logic [WIDTH-1:0]           ras_top,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_lost
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0] sp_q, sp_d, top_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lost_q, lost_d;
  logic [WIDTH-1:0] step, tgt, tvec;
  logic empty, full, act, push, pop, swap;
  assign step = (C_EXT && half) ? WIDTH'(2) : WIDTH'(4);
  assign tgt = {target[WIDTH-1:1], 1'b0};
  assign tvec = {trap_vector[WIDTH-1:1], 1'b0};
  // sp points at the next free slot; the top entry sits one below it (modulo depth)
  assign top_idx = sp_q - PW'(1);
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(RAS_DEPTH);
  assign act = en && !trap;
  // call+ret on an empty stack degenerates into a plain push
  assign push = act && call && (!ret || empty);
  assign swap = act && call && ret && !empty;
  assign pop = act && ret && !call && !empty;
  assign pc = pc_q;
  assign pc_plus_len = pc_q + step;
  assign ras_top = empty ? '0 : mem_q[top_idx];
  assign ras_count = cnt_q;
  assign ras_lost = lost_q;
  assign pc_d = !en ? pc_q :
                trap ? tvec :
                (ret && !empty) ? ras_top :
                (ret || load || call) ? tgt : pc_plus_len;
  always_comb begin
    mem_d = mem_q;
    sp_d = sp_q;
    cnt_d = cnt_q;
    lost_d = lost_q;
    if (push) begin
      // when full, sp already addresses the oldest entry, so the write overwrites it
      mem_d[sp_q] = pc_plus_len;
      sp_d = sp_q + PW'(1);
      cnt_d = full ? cnt_q : cnt_q + CW'(1);
      lost_d = lost_q | full;
    end
    if (swap) mem_d[top_idx] = pc_plus_len;
    if (pop) begin
      sp_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
    if (ras_flush) begin
      sp_d = '0;
      cnt_d = '0;
      lost_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
      mem_q <= '{default: '0};
      sp_q <= '0;
      cnt_q <= '0;
      lost_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      mem_q <= mem_d;
      sp_q <= sp_d;
      cnt_q <= cnt_d;
      lost_q <= lost_d;
    end
  end
endmodule
